// File: rtl/oct_code_capture_fifo_pkg.sv
// Shared definitions for the octal code capture FIFO.
// Optional stability filter: OCT_CAPTURE_STABLE_FILTER_EN.
package oct_code_capture_fifo_pkg;

  localparam int unsigned CODE_W        = 3;
  localparam int unsigned DEPTH_DEFAULT = 4;

  // Event-detect filter states (used only with the stability filter).
  typedef enum logic [1:0] {
    IDLE,
    SETTLING,
    EMITTED
  } detect_state_t;

endpackage

// File: rtl/oct_code_capture_fifo_if.sv
// Handshake bundle between the capture FIFO and its encoder/consumer.
// Optional stability filter: OCT_CAPTURE_STABLE_FILTER_EN (no effect here).
interface oct_code_capture_fifo_if
  import oct_code_capture_fifo_pkg::*;
#(
  parameter int unsigned PTR_W = 2
);

  logic              Valid_in;
  logic [CODE_W-1:0] Bin_in;
  logic              Out_ready;
  logic              Clear_ovf;
  logic              Out_valid;
  logic [CODE_W-1:0] Out_code;
  logic [PTR_W:0]    Count;
  logic              Full;
  logic              Overflow;

  modport master (
    output Valid_in, Bin_in, Out_ready, Clear_ovf,
    input  Out_valid, Out_code, Count, Full, Overflow
  );

  modport slave (
    input  Valid_in, Bin_in, Out_ready, Clear_ovf,
    output Out_valid, Out_code, Count, Full, Overflow
  );

endinterface

// File: rtl/oct_code_event_detect.sv
// Input stage and change detector: turns encoder Valid/Bin into one-shot events.
// Optional stability filter: OCT_CAPTURE_STABLE_FILTER_EN.
module oct_code_event_detect
  import oct_code_capture_fifo_pkg::*;
`ifdef OCT_CAPTURE_STABLE_FILTER_EN
#(
  parameter int unsigned STABLE_CYCLES = 3
)
`endif
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [CODE_W-1:0] bin_in,
  output logic              evt,
  output logic [CODE_W-1:0] code
);

  logic              vq;
  logic              vp;
  logic [CODE_W-1:0] bq;
  logic [CODE_W-1:0] bp;

  // Register the encoder outputs and keep the previous sample alongside.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vq <= 1'b0;
      vp <= 1'b0;
      bq <= '0;
      bp <= '0;
    end else begin
      vq <= valid_in;
      vp <= vq;
      bq <= bin_in;
      bp <= bq;
    end
  end

`ifdef OCT_CAPTURE_STABLE_FILTER_EN

  localparam int unsigned       CNT_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  detect_state_t     state;
  detect_state_t     state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              changed;
  logic              hit;
  logic              have_last;
  logic [CODE_W-1:0] last_code;

  // Change of the registered pair and the "stable long enough" condition.
  always_comb begin
    changed = (vq != vp) || (bq != bp);
    hit     = !changed && (cnt == CNT_MAX) && vq;
  end

  // Saturating stability counter, restarted on any change of {Vq,Bq}.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (changed) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: any change restarts settling; a settled code is consumed once.
  always_comb begin
    state_nxt = state;
    if (changed) begin
      state_nxt = vq ? SETTLING : IDLE;
    end else if ((state == SETTLING) && hit) begin
      state_nxt = EMITTED;
    end
  end

  // Outputs: emit only if the settled code is new or Valid dropped since the last one.
  always_comb begin
    evt  = (state == SETTLING) && hit && (!have_last || (bq != last_code));
    code = bq;
  end

  // Remember the last emitted code; a low Valid forgets it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      have_last <= 1'b0;
      last_code <= '0;
    end else if (!vq) begin
      have_last <= 1'b0;
    end else if (evt) begin
      have_last <= 1'b1;
      last_code <= bq;
    end
  end

`else

  // Rising Valid, or a code change while Valid stays high.
  always_comb begin
    evt  = vq & (~vp | (bq != bp));
    code = bq;
  end

`endif

endmodule

// File: rtl/oct_code_capture_fifo.sv
// Captures encoder codes as events into a small show-ahead FIFO with sticky overflow.
// Optional stability filter: OCT_CAPTURE_STABLE_FILTER_EN.
module oct_code_capture_fifo
  import oct_code_capture_fifo_pkg::*;
#(
  parameter int unsigned DEPTH         = DEPTH_DEFAULT,
  parameter int unsigned PTR_W         = 2,
  parameter int unsigned STABLE_CYCLES = 3
)
(
  input logic                     clk,
  input logic                     rst_n,
  oct_code_capture_fifo_if.slave  bus
);

  if ((DEPTH != (1 << PTR_W)) || (DEPTH < 2) || (DEPTH > 16) || (STABLE_CYCLES < 1)) begin : g_param_err
    $error("oct_code_capture_fifo: inconsistent DEPTH/PTR_W/STABLE_CYCLES");
  end

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic              evt;
  logic [CODE_W-1:0] evt_code;

  logic [CODE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              ovf;
  logic              full;
  logic              empty;
  logic              pop;
  logic              push;
  logic              drop;

`ifdef OCT_CAPTURE_STABLE_FILTER_EN
  oct_code_event_detect #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_detect (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (bus.Valid_in),
    .bin_in   (bus.Bin_in),
    .evt      (evt),
    .code     (evt_code)
  );
`else
  oct_code_event_detect u_detect (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (bus.Valid_in),
    .bin_in   (bus.Bin_in),
    .evt      (evt),
    .code     (evt_code)
  );
`endif

  // Handshake decode; a pop at Full frees the slot the same-cycle push needs.
  always_comb begin
    full  = (count == DEPTH_C);
    empty = (count == '0);
    pop   = !empty && bus.Out_ready;
    push  = evt && (!full || pop);
    drop  = evt && full && !pop;
  end

  // Storage; cleared on reset so the show-ahead head reads zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= evt_code;
    end
  end

  // Pointers and occupancy; Count is kept independently of the pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (bus.Clear_ovf) begin
      ovf <= 1'b0;
    end
  end

  // Output drive.
  always_comb begin
    bus.Out_valid = !empty;
    bus.Out_code  = mem[rd_ptr];
    bus.Count     = count;
    bus.Full      = full;
    bus.Overflow  = ovf;
  end

endmodule

// File: tb/tb_oct_code_capture_fifo.sv
// Scoreboard bench for oct_code_capture_fifo (default build, DEPTH=4).
module tb_oct_code_capture_fifo;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q [$];

  oct_code_capture_fifo_if #(.PTR_W(2)) bus ();

  oct_code_capture_fifo #(
    .DEPTH         (4),
    .PTR_W         (2),
    .STABLE_CYCLES (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Monitor: every accepted head entry is compared with the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.Out_valid && bus.Out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0d expected none", bus.Out_code);
      end else begin
        chk("pop_code", int'(bus.Out_code), int'(exp_q.pop_front()));
      end
    end
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n         = 1'b0;
    bus.Valid_in  = 1'b0;
    bus.Bin_in    = 3'd0;
    bus.Out_ready = 1'b0;
    bus.Clear_ovf = 1'b0;

    // Reset then idle
    ticks(2);
    @(negedge clk);
    chk("rst_count", int'(bus.Count), 0);
    chk("rst_valid", int'(bus.Out_valid), 0);
    chk("rst_ovf", int'(bus.Overflow), 0);
    chk("rst_full", int'(bus.Full), 0);
    tick();
    rst_n = 1'b1;

    // Single held code: one entry, two-cycle latency
    tick();
    bus.Valid_in = 1'b1;
    bus.Bin_in   = 3'd5;
    exp_q.push_back(3'd5);
    @(negedge clk);
    chk("lat_e0_valid", int'(bus.Out_valid), 0);
    tick();
    @(negedge clk);
    chk("lat_e1_valid", int'(bus.Out_valid), 0);
    tick();
    @(negedge clk);
    chk("lat_e2_valid", int'(bus.Out_valid), 1);
    chk("single_code", int'(bus.Out_code), 5);
    chk("single_count", int'(bus.Count), 1);
    ticks(8);
    @(negedge clk);
    chk("held_count", int'(bus.Count), 1);
    tick();
    bus.Out_ready = 1'b1;
    tick();
    bus.Out_ready = 1'b0;
    @(negedge clk);
    chk("drain1_count", int'(bus.Count), 0);

    // Code changes with Valid held high: 2,2,6,6,1
    tick(); bus.Bin_in = 3'd2; exp_q.push_back(3'd2);
    tick(); bus.Bin_in = 3'd2;
    tick(); bus.Bin_in = 3'd6; exp_q.push_back(3'd6);
    tick(); bus.Bin_in = 3'd6;
    tick(); bus.Bin_in = 3'd1; exp_q.push_back(3'd1);
    ticks(3);
    @(negedge clk);
    chk("seq_count", int'(bus.Count), 3);
    chk("seq_head", int'(bus.Out_code), 2);
    tick();
    bus.Out_ready = 1'b1;
    ticks(3);
    bus.Out_ready = 1'b0;
    @(negedge clk);
    chk("drain2_count", int'(bus.Count), 0);

    // Overflow: five events into four slots
    tick(); bus.Bin_in = 3'd3; exp_q.push_back(3'd3);
    tick(); bus.Bin_in = 3'd4; exp_q.push_back(3'd4);
    tick(); bus.Bin_in = 3'd5; exp_q.push_back(3'd5);
    tick(); bus.Bin_in = 3'd6; exp_q.push_back(3'd6);
    tick(); bus.Bin_in = 3'd0;
    ticks(3);
    @(negedge clk);
    chk("ovf_count", int'(bus.Count), 4);
    chk("ovf_full", int'(bus.Full), 1);
    chk("ovf_flag", int'(bus.Overflow), 1);
    chk("ovf_head", int'(bus.Out_code), 3);
    tick();
    bus.Clear_ovf = 1'b1;
    tick();
    bus.Clear_ovf = 1'b0;
    @(negedge clk);
    chk("clr_ovf", int'(bus.Overflow), 0);
    chk("clr_count", int'(bus.Count), 4);

    // Full with simultaneous push (code 7) and pop
    tick();
    bus.Bin_in = 3'd7;
    exp_q.push_back(3'd7);
    tick();
    bus.Out_ready = 1'b1;
    tick();
    bus.Out_ready = 1'b0;
    @(negedge clk);
    chk("pp_count", int'(bus.Count), 4);
    chk("pp_ovf", int'(bus.Overflow), 0);
    chk("pp_full", int'(bus.Full), 1);
    chk("pp_head", int'(bus.Out_code), 4);
    tick();
    bus.Out_ready = 1'b1;
    ticks(5);
    bus.Out_ready = 1'b0;
    @(negedge clk);
    chk("drain3_count", int'(bus.Count), 0);
    chk("drain3_valid", int'(bus.Out_valid), 0);
    chk("drain3_full", int'(bus.Full), 0);

    // Valid falling gives nothing; rising again with the same code gives an event
    tick();
    bus.Valid_in = 1'b0;
    ticks(3);
    @(negedge clk);
    chk("fall_count", int'(bus.Count), 0);
    tick(); bus.Valid_in = 1'b1; exp_q.push_back(3'd7);
    tick(); bus.Bin_in = 3'd2; exp_q.push_back(3'd2);
    tick(); bus.Bin_in = 3'd3; exp_q.push_back(3'd3);
    ticks(2);
    @(negedge clk);
    chk("pre_rst_count", int'(bus.Count), 3);

    // Reset mid-stream flushes; held Valid then yields a fresh event
    tick();
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    exp_q.push_back(3'd3);
    @(negedge clk);
    chk("mid_rst_count", int'(bus.Count), 0);
    chk("mid_rst_valid", int'(bus.Out_valid), 0);
    tick();
    @(negedge clk);
    chk("post_rst_e1_valid", int'(bus.Out_valid), 0);
    tick();
    @(negedge clk);
    chk("post_rst_e2_valid", int'(bus.Out_valid), 1);
    chk("post_rst_code", int'(bus.Out_code), 3);
    chk("post_rst_count", int'(bus.Count), 1);
    tick();
    bus.Out_ready = 1'b1;
    ticks(2);
    bus.Out_ready = 1'b0;
    @(negedge clk);
    chk("final_count", int'(bus.Count), 0);
    chk("scoreboard_left", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
